// File: rtl/fetch_queue_unit.sv
// Prefetching instruction-fetch front end: one outstanding READ to a variable-latency
// memory, fetched words queued with their PC tags in a DEPTH-entry FIFO for the decoder.
module fetch_queue_unit #(
    parameter int              AW       = 9,
    parameter int              DW       = 16,
    parameter int              DEPTH    = 4,
    parameter logic [AW-1:0]   RESET_PC = '0,
    localparam int             CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          ir_valid,
    output logic [DW-1:0] ir_out,
    output logic [AW-1:0] ir_pc,
    input  logic          ir_take,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    input  logic          halt,
    output logic [CW-1:0] count
);

    localparam int         PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_READ = 2'b01;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_WAIT  = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      mem_cmd_q, mem_cmd_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [AW-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

    logic [DW-1:0]   data_q [DEPTH];
    logic [AW-1:0]   tag_q  [DEPTH];

    logic push, pop, issue, launch;

    // Redirect outranks everything: a completing word is dropped and the pop is ignored.
    assign push = (state_q == ST_WAIT) && mem_ready && !redirect;
    assign pop  = ir_take && (count_q != '0) && !redirect;

    always_comb begin
        count_d = count_q;
        if (redirect)
            count_d = '0;
        else if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
    end

    // Using post-edge occupancy keeps a slot free for the word still in flight.
    assign issue  = !halt && (count_d < CW'(DEPTH));
    assign launch = issue && ((state_q == ST_RUN) || mem_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            mem_cmd_q  <= CMD_NONE;
            mem_addr_q <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            mem_cmd_q  <= mem_cmd_d;
            mem_addr_q <= mem_addr_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   state_d = issue ? ST_WAIT : ST_RUN;
            ST_WAIT: begin
                if (mem_ready)
                    state_d = issue ? ST_WAIT : ST_RUN;
                else if (redirect)
                    state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (mem_ready)
                    state_d = issue ? ST_WAIT : ST_RUN;
            end
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        mem_cmd_d  = (state_d == ST_RUN) ? CMD_NONE : CMD_READ;
        fetch_pc_d = fetch_pc_q;
        if (state_q == ST_WAIT && mem_ready)
            fetch_pc_d = mem_addr_q + AW'(1);
        if (redirect)
            fetch_pc_d = redirect_pc;
        mem_addr_d = launch ? fetch_pc_d : mem_addr_q;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= mem_rdata;
            tag_q[wr_ptr_q]  <= mem_addr_q;
        end
    end

    assign mem_cmd  = mem_cmd_q;
    assign mem_addr = mem_addr_q;
    assign count    = count_q;
    assign ir_valid = (count_q != '0);
    assign ir_out   = ir_valid ? data_q[rd_ptr_q] : '0;
    assign ir_pc    = ir_valid ? tag_q[rd_ptr_q]  : '0;

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch front end for the RISC machine. Replaces the single PC register, instruction register and addr_sel path with a prefetching fetch engine.
- Issues instruction reads to a variable-latency memory using a ready handshake. Buffers fetched words, each tagged with its PC, in a DEPTH-entry FIFO that feeds the instruction decoder.
- Supports branch/return redirect with flush, and a halt hold.

Parameters:
- AW, 9, instruction address width in words.
- DW, 16, instruction word width.
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 0, fetch address after reset, AW bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- mem_cmd  output  2  2'b00 = NONE, 2'b01 = READ; registered.
- mem_addr  output  AW  read address; registered.
- mem_rdata  input  DW  read data; valid when mem_ready=1.
- mem_ready  input  1  memory completes the current READ at this edge.
- ir_valid  output  1  FIFO head is valid.
- ir_out  output  DW  FIFO head instruction.
- ir_pc  output  AW  address ir_out was fetched from.
- ir_take  input  1  decoder consumes the head this edge.
- redirect  input  1  flush the FIFO and restart fetch at redirect_pc.
- redirect_pc  input  AW  new fetch address.
- halt  input  1  level; no new READs are issued while high.
- count  output  clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - mem_cmd=NONE, mem_addr=RESET_PC, internal fetch_pc=RESET_PC.
  - FIFO empty: count=0, ir_valid=0, ir_out=0, ir_pc=0.
  - state=RUN.
- States:
  - RUN: no request outstanding.
  - WAIT: READ outstanding.
  - FLUSH: READ outstanding whose data will be discarded.
- Handshake:
  - At most one READ outstanding.
  - While in WAIT or FLUSH, mem_cmd=READ and mem_addr are held stable until an edge with mem_ready=1. mem_ready is ignored in RUN.
- Issue condition, evaluated each edge: halt=0 and next_count < DEPTH, where next_count is occupancy after this edge's push/pop. This reserves a slot for the outstanding word, so the FIFO never overflows.
- RUN:
  - If issue: mem_cmd<=READ, mem_addr<=fetch_pc, go to WAIT.
  - Otherwise mem_cmd<=NONE.
- WAIT with mem_ready=1:
  - Push {mem_rdata, mem_addr}.
  - fetch_pc<=mem_addr+1, modulo 2^AW (address 2^AW-1 wraps to 0).
  - If issue: stay in WAIT with mem_addr<=mem_addr+1. This gives back-to-back reads, 1 word/cycle at zero wait.
  - Otherwise go to RUN with mem_cmd<=NONE.
- Latency: a word accepted at edge N is visible at the head (ir_valid=1) after edge N when the FIFO was empty. ir_out and ir_pc come from the head register, with no combinational path from mem_rdata.
- Pop: on an edge with ir_take=1 and ir_valid=1. ir_take while empty is ignored.
- Push and pop on the same edge: count is unchanged and the head advances.
- Redirect (highest priority):
  - FIFO cleared (count<=0, ir_valid<=0); ir_take ignored that edge; fetch_pc<=redirect_pc.
  - From RUN: issue READ at redirect_pc on the same edge if halt=0.
  - From WAIT without mem_ready: go to FLUSH; the outstanding READ is not aborted.
  - From WAIT with mem_ready on the same edge: data discarded; READ at redirect_pc issued if halt=0.
- FLUSH:
  - On mem_ready: discard data; issue READ at fetch_pc if halt=0, otherwise go to RUN.
  - A further redirect in FLUSH updates fetch_pc only.
- Halt: an outstanding READ still completes and is pushed. The FIFO keeps draining via ir_take. Fetch resumes at fetch_pc on the first edge with halt=0. A redirect while halted updates fetch_pc and flushes.
- Reset mid-operation: immediately returns to the reset values, and any outstanding READ is abandoned. The memory must tolerate mem_cmd dropping to NONE.
- count is always between 0 and DEPTH. ir_valid equals (count != 0).

Test Plan:
- Reset release, mem_ready=1, ir_take=0, DEPTH=4 -> mem_addr 0,1,2,3 on consecutive cycles; then mem_cmd=NONE; count=4; ir_out=mem[0], ir_pc=0.
- Steady stream, mem_ready=1, ir_take=1 every cycle -> one instruction per cycle; ir_pc sequence 0,1,2,…; count stays at most 1; no extra READs.
- Two wait states per read (mem_ready high every third cycle) -> mem_addr held stable over 3 cycles per address; pushed words match their ir_pc tags.
- Redirect to 0x40 while the READ of 0x05 is pending for 2 more cycles -> FLUSH entered; word for 0x05 dropped; next READ addr=0x40; first ir_pc after flush = 0x40.
- RESET_PC=511, AW=9 -> fetch order 511, 0, 1; ir_pc wraps accordingly.
- Halt asserted during WAIT, then reset pulsed low mid-READ -> the pending word is pushed and no new READ is issued; on reset, mem_cmd=NONE, count=0, mem_addr=RESET_PC asynchronously.
